// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-product coin vending FSM with serial change/refund output
module vending_machine_multi #(
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = 2,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 60,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd40, 8'd25, 8'd20, 8'd15},
    parameter bit AUTO_VEND  = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          in_i,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic                vend_i,
    input  logic                cancel_i,
    output logic                out_o,
    output logic [SEL_W-1:0]    item_o,
    output logic [1:0]          change_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o,
    output logic                deny_o,
    output logic                coin_reject_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_CHANGE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                out_q, out_d;
    logic [SEL_W-1:0]    item_q, item_d;
    logic [1:0]          change_q, change_d;
    logic                busy_q, busy_d;
    logic                deny_q, deny_d;
    logic                rej_q, rej_d;

    logic                locked;
    logic                coin;
    logic                do_vend;
    logic [SEL_W-1:0]    vsel;
    logic                sel_ok;
    logic [CREDIT_W-1:0] vprice;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;

    localparam logic [CREDIT_W-1:0] PRICE0 = PRICES[CREDIT_W-1:0];
    localparam logic [CREDIT_W-1:0] TEN    = CREDIT_W'(10);

    always_comb begin
        vprice = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (vsel == SEL_W'(i)) begin
                vprice = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        case (in_i)
            2'b01:   coin_val = (CREDIT_W+1)'(5);
            2'b10:   coin_val = (CREDIT_W+1)'(10);
            2'b11:   coin_val = (CREDIT_W+1)'(20);
            default: coin_val = '0;
        endcase
    end

    // Legacy mode treats reaching price0 as an implicit vend of item 0 on the next edge.
    assign do_vend = AUTO_VEND ? (credit_q >= PRICE0) : vend_i;
    assign vsel    = AUTO_VEND ? '0 : sel_i;
    assign locked  = out_q | (state_q == S_CHANGE);
    assign coin    = (in_i != 2'b00);
    assign sum     = {1'b0, credit_q} + coin_val;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        out_d    = 1'b0;
        item_d   = '0;
        change_d = 2'b00;
        deny_d   = 1'b0;
        rej_d    = 1'b0;

        if (state_q == S_CHANGE) begin
            if (credit_q >= TEN) begin
                change_d = 2'b10;
                credit_d = credit_q - TEN;
            end else begin
                change_d = 2'b01;
                credit_d = '0;
            end
            if (credit_d == '0) begin
                state_d = S_IDLE;
            end
        end

        if (locked) begin
            rej_d  = coin;
            deny_d = vend_i & ~AUTO_VEND;
        end else if (cancel_i) begin
            rej_d = coin;
            if (credit_q != '0) begin
                state_d = S_CHANGE;
            end
        end else if (do_vend) begin
            rej_d = coin;
            if (sel_ok && credit_q >= vprice) begin
                out_d    = 1'b1;
                item_d   = vsel;
                credit_d = credit_q - vprice;
                state_d  = (credit_d != '0) ? S_CHANGE : S_IDLE;
            end else begin
                deny_d = 1'b1;
            end
        end else if (coin) begin
            if (sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                credit_d = sum[CREDIT_W-1:0];
                state_d  = S_CREDIT;
            end else begin
                rej_d = 1'b1;
            end
        end

        busy_d = out_d | (state_d == S_CHANGE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            out_q    <= 1'b0;
            item_q   <= '0;
            change_q <= 2'b00;
            busy_q   <= 1'b0;
            deny_q   <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            out_q    <= out_d;
            item_q   <= item_d;
            change_q <= change_d;
            busy_q   <= busy_d;
            deny_q   <= deny_d;
            rej_q    <= rej_d;
        end
    end

    assign out_o         = out_q;
    assign item_o        = item_q;
    assign change_o      = change_q;
    assign credit_o      = credit_q;
    assign busy_o        = busy_q;
    assign deny_o        = deny_q;
    assign coin_reject_o = rej_q;

endmodule
